// File: rtl/exec_controller_if.sv
// Host command port of the run-control sequencer: the host is the master, the controller the slave.
interface exec_controller_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        cmd_err;

    modport master (output cmd_valid, output cmd_op, output cmd_arg,
                    input  cmd_ready, input  cmd_err);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg,
                    output cmd_ready, output cmd_err);
endinterface

// File: rtl/exec_controller.sv
// Run-control sequencer for the single-cycle datapath: boot, free run, N-step,
// PC breakpoint and halt-on-EBREAK, with a retired-instruction counter.
module exec_controller #(
    parameter logic [31:0] RESET_START = 32'h0000_0000,
    parameter logic [31:0] EBREAK_ENC  = 32'h0010_0073
) (
    input  logic             clk,
    input  logic             rst,
    exec_controller_if.slave cmd,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             hlt,
    output logic             preset,
    output logic [31:0]      start_addr,
    output logic [1:0]       state,
    output logic [2:0]       halt_cause,
    output logic [31:0]      retired
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [2:0] OP_SET_START = 3'd1;
    localparam logic [2:0] OP_BOOT      = 3'd2;
    localparam logic [2:0] OP_RUN       = 3'd3;
    localparam logic [2:0] OP_STEP      = 3'd4;
    localparam logic [2:0] OP_HALT      = 3'd5;
    localparam logic [2:0] OP_SET_BP    = 3'd6;
    localparam logic [2:0] OP_CLR_BP    = 3'd7;

    localparam logic [2:0] CAUSE_RESET  = 3'd0;
    localparam logic [2:0] CAUSE_HOST   = 3'd1;
    localparam logic [2:0] CAUSE_STEP   = 3'd2;
    localparam logic [2:0] CAUSE_BP     = 3'd3;
    localparam logic [2:0] CAUSE_EBREAK = 3'd4;
    localparam logic [2:0] CAUSE_BOOT   = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  cause_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        err_d;
    logic        run_en, enabled, accept, host_halt, exec_edge, run_op;

    assign run_en        = (state_q != ST_HALT);
    assign enabled       = ~hlt;
    assign cmd.cmd_ready = (state_q != ST_BOOT);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign host_halt     = accept && (cmd.cmd_op == OP_HALT);
    assign run_op        = (cmd.cmd_op == OP_BOOT) || (cmd.cmd_op == OP_RUN) ||
                           (cmd.cmd_op == OP_STEP);
    assign exec_edge     = enabled && ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign preset        = (state_q == ST_BOOT);
    assign state         = state_q;

    // hlt only moves while clk is low, so the datapath's gated clock stays glitch-free.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            hlt <= 1'b1;
        end else begin
            hlt <= ~run_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HALT;
            halt_cause <= CAUSE_RESET;
            steps_q    <= 32'd0;
            retired    <= 32'd0;
            start_addr <= RESET_START;
            bp_addr    <= 32'd0;
            bp_en      <= 1'b0;
            cmd.cmd_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_cause  <= cause_d;
            steps_q     <= steps_d;
            cmd.cmd_err <= err_d;
            if (exec_edge) begin
                retired <= retired + 32'd1;
            end
            if (accept) begin
                case (cmd.cmd_op)
                    OP_SET_START: start_addr <= cmd.cmd_arg;
                    OP_SET_BP: begin
                        bp_addr <= cmd.cmd_arg;
                        bp_en   <= 1'b1;
                    end
                    OP_CLR_BP: bp_en <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Halt checks look at the instruction executing on this edge, so the PC stops at its successor.
    always_comb begin
        state_d = state_q;
        cause_d = halt_cause;
        steps_d = steps_q;
        err_d   = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_BOOT: state_d = ST_BOOT;
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: begin
                            state_d = ST_STEP;
                            steps_d = (cmd.cmd_arg == 32'd0) ? 32'd1 : cmd.cmd_arg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BOOT: begin
                if (enabled) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BOOT;
                end
            end
            default: begin
                err_d = accept && run_op;
                if (enabled && (state_q == ST_STEP)) begin
                    steps_d = steps_q - 32'd1;
                end
                if (enabled && (instr == EBREAK_ENC)) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_EBREAK;
                end else if (enabled && bp_en && (pc == bp_addr)) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if (host_halt) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HOST;
                end else if (enabled && (state_q == ST_STEP) && (steps_q == 32'd1)) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_STEP;
                end
            end
        endcase
    end

endmodule
